// File: rtl/exec_core_pkg.sv
// rtl/exec_core_pkg.sv - opcodes, FSM states, fault codes and memory-op kinds for exec_core
package exec_core_pkg;

    localparam logic [15:0] OP_MOVREG = 16'h0E1A;
    localparam logic [15:0] OP_MOVNUM = 16'h0E3A;
    localparam logic [15:0] OP_SVC    = 16'h0EF0;
    localparam logic [15:0] OP_LDR    = 16'h0E59;
    localparam logic [15:0] OP_STRREG = 16'h0E78;
    localparam logic [15:0] OP_STRNUM = 16'h0E58;
    localparam logic [15:0] OP_SUBNUM = 16'h0E24;
    localparam logic [15:0] OP_SUBREG = 16'h0E04;
    localparam logic [15:0] OP_ADDNUM = 16'h0E28;
    localparam logic [15:0] OP_ADDREG = 16'h0E08;
    localparam logic [15:0] OP_ANDNUM = 16'h0E20;
    localparam logic [15:0] OP_ANDREG = 16'h0E00;
    localparam logic [15:0] OP_ORNUM  = 16'h0E38;
    localparam logic [15:0] OP_ORREG  = 16'h0E18;
    localparam logic [15:0] OP_PUSH   = 16'h0E52;
    localparam logic [15:0] OP_POP    = 16'h0E49;

    typedef enum logic [1:0] {IDLE, MEM, FAULT} state_t;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_BAD   = 2'd1;
    localparam logic [1:0] FC_STACK = 2'd2;
    localparam logic [1:0] FC_STORE = 2'd3;

    typedef enum logic [1:0] {LD, ST, PUSH, POP} mem_kind_t;

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational ALU; y = a op b, MOV forms pass b through
import exec_core_pkg::*;

module exec_alu #(
    parameter int DATA_W = 32
) (
    input  logic [15:0]       op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_MOVREG, OP_MOVNUM: y = b;
            OP_ADDREG, OP_ADDNUM: y = a + b;
            OP_SUBREG, OP_SUBNUM: y = a - b;
            OP_ANDREG, OP_ANDNUM: y = a & b;
            OP_ORREG,  OP_ORNUM:  y = a | b;
            default:              y = a;
        endcase
    end

endmodule

// File: rtl/exec_core.sv
// rtl/exec_core.sv - multi-cycle execution core: single-cycle ALU ops, memory ops via req/ack,
// sticky fault status
import exec_core_pkg::*;

module exec_core #(
    parameter int                DATA_W      = 32,
    parameter int                NREGS       = 16,
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] STACK_TOP   = 24'h7A1200,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 24'h000000,
    parameter logic [ADDR_W-1:0] STORE_LIMIT = 24'h7A1200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [15:0]              opcode,
    input  logic [DATA_W-1:0]        op_a,
    input  logic [DATA_W-1:0]        op_b,
    input  logic [DATA_W-1:0]        op_c,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack,
    output logic                     svc_valid,
    output logic [DATA_W-1:0]        svc_num,
    output logic                     fault,
    output logic [1:0]               fault_code,
    input  logic [$clog2(NREGS)-1:0] dbg_idx,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [31:0]              retired
);

    localparam int IDX_W = $clog2(NREGS);

    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] sp;
    state_t            state;
    mem_kind_t         cur_kind;
    logic [IDX_W-1:0]  dest;

    logic [IDX_W-1:0]  ia, ib, ic;
    logic [DATA_W-1:0] ra, rb, rc, alu_b, alu_y, sum;
    logic              a_ok, b_ok, c_ok;
    logic              known, is_alu, is_svc, use_b, use_c;
    mem_kind_t         kind;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        fc;

    assign ia   = op_a[IDX_W-1:0];
    assign ib   = op_b[IDX_W-1:0];
    assign ic   = op_c[IDX_W-1:0];
    assign a_ok = (op_a >> IDX_W) == '0;
    assign b_ok = (op_b >> IDX_W) == '0;
    assign c_ok = (op_c >> IDX_W) == '0;
    assign ra   = regs[ia];
    assign rb   = regs[ib];
    assign rc   = regs[ic];

    assign issue_ready = (state == IDLE);
    assign fault       = (fault_code != FC_NONE);
    assign dbg_data    = regs[dbg_idx];

    always_comb begin
        known  = 1'b1;
        is_alu = 1'b0;
        is_svc = 1'b0;
        use_b  = 1'b0;
        use_c  = 1'b0;
        kind   = LD;
        case (opcode)
            OP_MOVNUM, OP_ADDNUM, OP_SUBNUM, OP_ANDNUM, OP_ORNUM: is_alu = 1'b1;
            OP_MOVREG, OP_ADDREG, OP_SUBREG, OP_ANDREG, OP_ORREG: begin
                is_alu = 1'b1;
                use_b  = 1'b1;
            end
            OP_SVC:    is_svc = 1'b1;
            OP_LDR:    begin use_b = 1'b1; use_c = 1'b1; kind = LD; end
            OP_STRREG: begin use_b = 1'b1; use_c = 1'b1; kind = ST; end
            OP_STRNUM: begin use_b = 1'b1; kind = ST; end
            OP_PUSH:   kind = PUSH;
            OP_POP:    kind = POP;
            default:   known = 1'b0;
        endcase
    end

    assign alu_b = use_b ? rb : op_b;
    assign sum   = rb + (use_c ? rc : op_c);

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .op (opcode),
        .a  (ra),
        .b  (alu_b),
        .y  (alu_y)
    );

    // Address and fault priority: bad encoding first, then stack, then store limit.
    always_comb begin
        addr = sum[ADDR_W-1:0];
        if (kind == PUSH)     addr = sp - ADDR_W'(4);
        else if (kind == POP) addr = sp;
        fc = FC_NONE;
        if (!known || (!is_svc && !a_ok) || (use_b && !b_ok) || (use_c && !c_ok))
            fc = FC_BAD;
        else if (!is_alu && !is_svc && kind == PUSH &&
                 {1'b0, sp} < ({1'b0, STACK_LIMIT} + (ADDR_W+1)'(4)))
            fc = FC_STACK;
        else if (!is_alu && !is_svc && kind == POP &&
                 ({1'b0, sp} + (ADDR_W+1)'(4)) > {1'b0, STACK_TOP})
            fc = FC_STACK;
        else if (!is_alu && !is_svc && kind == ST && addr >= STORE_LIMIT)
            fc = FC_STORE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            sp         <= STACK_TOP;
            state      <= IDLE;
            retired    <= '0;
            fault_code <= FC_NONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            svc_valid  <= 1'b0;
            svc_num    <= '0;
            cur_kind   <= LD;
            dest       <= '0;
        end else begin
            svc_valid <= 1'b0;
            case (state)
                IDLE: if (issue_valid) begin
                    if (fc != FC_NONE) begin
                        state      <= FAULT;
                        fault_code <= fc;
                    end else if (is_alu) begin
                        regs[ia] <= alu_y;
                        retired  <= retired + 32'd1;
                    end else if (is_svc) begin
                        svc_valid <= 1'b1;
                        svc_num   <= op_a;
                        retired   <= retired + 32'd1;
                    end else begin
                        state     <= MEM;
                        mem_req   <= 1'b1;
                        mem_we    <= (kind == ST) || (kind == PUSH);
                        mem_addr  <= addr;
                        mem_wdata <= ra;
                        cur_kind  <= kind;
                        dest      <= ia;
                    end
                end
                MEM: if (mem_ack) begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                    retired <= retired + 32'd1;
                    if (cur_kind == LD || cur_kind == POP) regs[dest] <= mem_rdata;
                    if (cur_kind == PUSH) sp <= mem_addr;
                    if (cur_kind == POP)  sp <= mem_addr + ADDR_W'(4);
                end
                FAULT: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_core.sv
// tb/tb_exec_core.sv - directed self-checking bench for exec_core
module tb_exec_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] opcode;
    logic [31:0] op_a, op_b, op_c;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        svc_valid;
    logic [31:0] svc_num;
    logic        fault;
    logic [1:0]  fault_code;
    logic [3:0]  dbg_idx;
    logic [31:0] dbg_data;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_core dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .svc_valid(svc_valid), .svc_num(svc_num),
        .fault(fault), .fault_code(fault_code), .dbg_idx(dbg_idx), .dbg_data(dbg_data),
        .retired(retired)
    );

    task automatic drive(input logic [15:0] op, input logic [31:0] a, b, c);
        opcode = op; op_a = a; op_b = b; op_c = c; issue_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        issue_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        opcode = '0; op_a = '0; op_b = '0; op_c = '0; dbg_idx = 4'd0;
        do_reset();
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", issue_ready); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 24'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_mem got req=%b we=%b addr=%h wdata=%h want 0", mem_req, mem_we, mem_addr, mem_wdata); end
        checks++; if (fault !== 1'b0 || fault_code !== 2'd0) begin errors++; $display("FAIL reset_fault got %b/%0d want 0/0", fault, fault_code); end
        checks++; if (svc_valid !== 1'b0 || svc_num !== 32'h0 || retired !== 32'h0) begin
            errors++; $display("FAIL reset_misc got svc=%b num=%h retired=%0d want 0", svc_valid, svc_num, retired); end
    endtask

    task automatic test_back_to_back();
        dbg_idx = 4'd1;
        drive(16'h0E3A, 1, 5, 0); step();
        checks++; if (dbg_data !== 32'd5) begin errors++; $display("FAIL movnum got %0d want 5", dbg_data); end
        drive(16'h0E28, 1, 7, 0); step();
        checks++; if (dbg_data !== 32'd12) begin errors++; $display("FAIL addnum got %0d want 12", dbg_data); end
        drive(16'h0E04, 1, 1, 0); step();
        issue_valid = 1'b0;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL subreg got %0d want 0", dbg_data); end
        checks++; if (retired !== 32'd3) begin errors++; $display("FAIL b2b_retired got %0d want 3", retired); end
    endtask

    task automatic test_store();
        drive(16'h0E3A, 2, 32'h100, 0); step();
        drive(16'h0E3A, 3, 4, 0); step();
        drive(16'h0E78, 1, 2, 3); step();
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 24'h000104 || mem_wdata !== 32'h0) begin
                errors++; $display("FAIL store_hold[%0d] got req=%b we=%b addr=%h wdata=%h want 1/1/000104/0", i, mem_req, mem_we, mem_addr, mem_wdata); end
            checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL store_busy[%0d] got %b want 0", i, issue_ready); end
            checks++; if (retired !== 32'd5) begin errors++; $display("FAIL store_pre_retired[%0d] got %0d want 5", i, retired); end
            if (i == 2) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || issue_ready !== 1'b1) begin errors++; $display("FAIL store_done got req=%b ready=%b want 0/1", mem_req, issue_ready); end
        checks++; if (retired !== 32'd6) begin errors++; $display("FAIL store_retired got %0d want 6", retired); end
    endtask

    task automatic test_push_pop();
        drive(16'h0E3A, 4, 32'hDEAD, 0); step();
        drive(16'h0E52, 4, 0, 0); step();
        issue_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 24'h7A11FC || mem_wdata !== 32'hDEAD) begin
            errors++; $display("FAIL push_req got req=%b we=%b addr=%h wdata=%h want 1/1/7a11fc/dead", mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        checks++; if (issue_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL push_done got ready=%b req=%b want 1/0", issue_ready, mem_req); end
        drive(16'h0E49, 5, 0, 0); step();
        issue_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 24'h7A11FC) begin
            errors++; $display("FAIL pop_req got req=%b we=%b addr=%h want 1/0/7a11fc", mem_req, mem_we, mem_addr); end
        mem_rdata = 32'hDEAD; mem_ack = 1'b1; step(); mem_ack = 1'b0; mem_rdata = '0;
        dbg_idx = 4'd5;
        checks++; if (dbg_data !== 32'hDEAD) begin errors++; $display("FAIL pop_data got %h want dead", dbg_data); end
        checks++; if (retired !== 32'd9) begin errors++; $display("FAIL pushpop_retired got %0d want 9", retired); end
        // sp is back at the top, so one more POP must underflow
        drive(16'h0E49, 6, 0, 0); step();
        issue_valid = 1'b0;
        checks++; if (fault_code !== 2'd2 || mem_req !== 1'b0) begin errors++; $display("FAIL sp_restored got code=%0d req=%b want 2/0", fault_code, mem_req); end
    endtask

    task automatic test_pop_fault();
        do_reset();
        drive(16'h0E49, 0, 0, 0); step();
        issue_valid = 1'b0;
        checks++; if (fault !== 1'b1 || fault_code !== 2'd2) begin errors++; $display("FAIL pop_fault got %b/%0d want 1/2", fault, fault_code); end
        checks++; if (issue_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL pop_fault_port got ready=%b req=%b want 0/0", issue_ready, mem_req); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        checks++; if (fault_code !== 2'd2 || mem_req !== 1'b0 || retired !== 32'd0) begin
            errors++; $display("FAIL fault_sticky got code=%0d req=%b retired=%0d want 2/0/0", fault_code, mem_req, retired); end
    endtask

    task automatic test_store_limit();
        do_reset();
        drive(16'h0E58, 1, 0, 32'h7A11FC); step();
        issue_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 24'h7A11FC || fault !== 1'b0) begin
            errors++; $display("FAIL store_below_limit got req=%b addr=%h fault=%b want 1/7a11fc/0", mem_req, mem_addr, fault); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        drive(16'h0E58, 1, 0, 32'h7A1200); step();
        issue_valid = 1'b0;
        checks++; if (fault_code !== 2'd3 || mem_req !== 1'b0 || retired !== 32'd1) begin
            errors++; $display("FAIL store_limit got code=%0d req=%b retired=%0d want 3/0/1", fault_code, mem_req, retired); end
        do_reset();
        checks++; if (fault !== 1'b0 || fault_code !== 2'd0 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL fault_clear got %b/%0d ready=%b want 0/0/1", fault, fault_code, issue_ready); end
    endtask

    task automatic test_bad_encoding();
        do_reset();
        drive(16'h1234, 0, 0, 0); step();
        issue_valid = 1'b0;
        checks++; if (fault_code !== 2'd1 || issue_ready !== 1'b0) begin errors++; $display("FAIL bad_opcode got code=%0d ready=%b want 1/0", fault_code, issue_ready); end
        do_reset();
        dbg_idx = 4'd15;
        drive(16'h0E3A, 15, 7, 0); step();
        checks++; if (dbg_data !== 32'd7 || fault !== 1'b0) begin errors++; $display("FAIL reg15 got %0d fault=%b want 7/0", dbg_data, fault); end
        drive(16'h0E3A, 16, 9, 0); step();
        issue_valid = 1'b0;
        checks++; if (fault_code !== 2'd1 || retired !== 32'd1) begin errors++; $display("FAIL bad_index got code=%0d retired=%0d want 1/1", fault_code, retired); end
    endtask

    task automatic test_svc();
        do_reset();
        drive(16'h0EF0, 9, 0, 0); step();
        issue_valid = 1'b0;
        checks++; if (svc_valid !== 1'b1 || svc_num !== 32'd9 || retired !== 32'd1) begin
            errors++; $display("FAIL svc_pulse got v=%b num=%0d retired=%0d want 1/9/1", svc_valid, svc_num, retired); end
        step();
        checks++; if (svc_valid !== 1'b0 || svc_num !== 32'd9) begin errors++; $display("FAIL svc_end got v=%b num=%0d want 0/9", svc_valid, svc_num); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        drive(16'h0E59, 6, 0, 0); step();
        issue_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL ldr_req got req=%b we=%b want 1/0", mem_req, mem_we); end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mid_mem got req=%b want 0", mem_req); end
        mem_rdata = 32'h55; mem_ack = 1'b1; step(); mem_ack = 1'b0;
        dbg_idx = 4'd6;
        checks++; if (dbg_data !== 32'h0 || retired !== 32'd0 || issue_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL late_ack got r6=%h retired=%0d ready=%b req=%b want 0/0/1/0", dbg_data, retired, issue_ready, mem_req); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_store();
        test_push_pop();
        test_pop_fault();
        test_store_limit();
        test_bad_encoding();
        test_svc();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_core.md
# exec_core

Parametrised multi-cycle execution core replacing the fixed single-cycle core. It accepts one decoded instruction at a time over a valid/ready issue port and executes register ALU operations in one cycle. Loads, stores, push and pop go through a request/acknowledge port to the external SRAM. Faults are reported through a sticky status port instead of stopping simulation. It sits between the instruction fetch/decode front end and the shared SRAM controller.

## Interface
Parameters:
- DATA_W, 32: register and memory data width.
- NREGS, 16: number of general registers; power of two, 4 to 32.
- ADDR_W, 24: byte address width of the memory port.
- STACK_TOP, 24'h7A1200: reset value of sp.
- STACK_LIMIT, 24'h000000: lowest legal sp.
- STORE_LIMIT, 24'h7A1200: stores to addresses at or above this value fault.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- issue_valid  in  1  instruction present.
- issue_ready  out  1  core can accept an instruction.
- opcode  in  16  operation code.
- op_a / op_b / op_c  in  DATA_W each  operands; register indices or immediates, depending on the opcode.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge.
- svc_valid  out  1  one-cycle pulse when an SVC instruction retires.
- svc_num  out  DATA_W  op_a of the last SVC.
- fault  out  1  sticky fault flag.
- fault_code  out  2  0 = none, 1 = bad opcode or register index, 2 = stack overflow/underflow, 3 = store limit.
- dbg_idx  in  log2(NREGS)  debug register select.
- dbg_data  out  DATA_W  combinational read of regs[dbg_idx].
- retired  out  32  count of retired instructions.

## Operation
- Opcodes:
  - MOVREG 0x0E1A, MOVNUM 0x0E3A, SVC 0x0EF0.
  - LDR 0x0E59, STRREG 0x0E78, STRNUM 0x0E58.
  - SUBNUM 0x0E24, SUBREG 0x0E04, ADDNUM 0x0E28, ADDREG 0x0E08.
  - ANDNUM 0x0E20, ANDREG 0x0E00, ORNUM 0x0E38, ORREG 0x0E18.
  - PUSH 0x0E52, POP 0x0E49.
- Notation: rA = regs[op_a], rB = regs[op_b], rC = regs[op_c]. "NUM" forms use op_b as an immediate.
- ALU ops (MOV/ADD/SUB/AND/OR): rA <= rA op (rB | op_b). Arithmetic is modulo 2^DATA_W; no flags.
- LDR: address = rB + rC, truncated to ADDR_W; rA <= mem_rdata.
- STRREG: address = rB + rC. STRNUM: address = rB + op_c. Both write rA.
- PUSH: sp <= sp − 4, then write rA at the new sp.
- POP: read at sp, rA <= data, then sp <= sp + 4.
- SVC: pulses svc_valid; no architectural state change.
- State machine:
  - IDLE: issue_ready = 1. An ALU op or SVC retires on the accepting edge and the core stays in IDLE. A memory op goes to MEM on the accepting edge, latching address, data and destination.
  - MEM: mem_req = 1; issue_ready = 0. On mem_ack: load data is written, sp is updated for PUSH/POP, the instruction retires, and the core returns to IDLE.
  - FAULT: issue_ready = 0 and mem_req = 0. The core stays in FAULT until rst_n is asserted.
- Fault checks are made at acceptance. A faulting instruction is consumed with no state change, does not retire, and moves the core to FAULT.
  - Unknown opcode, or op_a/op_b/op_c used as a register index ≥ NREGS → code 1.
  - PUSH with sp − 4 < STACK_LIMIT, or POP with sp + 4 > STACK_TOP → code 2.
  - Store address ≥ STORE_LIMIT → code 3.
- retired counts up by 1 per retired instruction and wraps at 2^32.

## Timing
- Reset (rst_n = 0 at a rising edge) sets:
  - all registers to 0; sp = STACK_TOP; state = IDLE; retired = 0.
  - fault = 0, fault_code = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - svc_valid = 0, svc_num = 0.
- Reset during MEM drops mem_req on that edge. A late mem_ack after reset is ignored.
- ALU latency: the result is visible on dbg_data in the cycle after acceptance. Back-to-back issue is allowed, and a dependent op reads the updated value.
- Memory ops: mem_req rises in the cycle after acceptance. mem_addr, mem_we and mem_wdata are stable while mem_req = 1. issue_ready returns in the cycle after mem_ack.
- Minimum memory-op occupancy is 2 cycles (acknowledge in the first request cycle).
- mem_ack while mem_req = 0 is ignored.
- svc_valid is high for exactly the cycle after SVC acceptance.

## Structure
- Package exec_core_pkg holds:
  - opcode localparams;
  - the state enum (IDLE, MEM, FAULT);
  - fault code constants;
  - the memory-op kind enum (LD, ST, PUSH, POP).
- One sub-module, exec_alu: combinational ALU with inputs op, a, b and output y. Register file, sp, FSM and counters stay in exec_core.

## Test plan
- Reset, then MOVNUM r1,5; ADDNUM r1,7; SUBREG r1,r1 issued back-to-back → r1 reads 5, 12, 0 on successive cycles; retired = 3.
- MOVNUM r2,0x100; MOVNUM r3,4; STRREG r1,r2,r3 with mem_ack after 3 cycles → mem_addr = 0x104 held 3 cycles; issue_ready = 0 throughout; retired increments once.
- PUSH r4 (r4 = 0xDEAD) then POP r5 → write at 0x7A11FC, then read at 0x7A11FC; r5 = 0xDEAD; sp back to 0x7A1200.
- POP immediately after reset → fault = 1, fault_code = 2, issue_ready = 0, no mem_req.
- STRNUM r1,r0,0x7A1200 → fault_code = 3; opcode 0x1234 after a fresh reset → fault_code = 1; rst_n low clears the fault.
- SVC with op_a = 9 → svc_valid is a 1-cycle pulse, svc_num = 9; reset asserted mid-MEM → mem_req = 0 on the next edge.
